// File: rtl/counter_sched.sv
// Purpose : round-robin owner of one shared WIDTH-bit up-counter for two interval requesters.
// Latency : grant registered 1 cycle after req; owner holds gnt for len+3 cycles; done pulses on the last of them.
// Backpr. : none; a requester simply waits (holding req) until it is granted, later req/len changes are ignored.
//
// Ports:
//   clock, clear      rising-edge clock, synchronous active-high reset
//   req[1:0]          interval requests, bit i = requester i
//   len0, len1        interval lengths, sampled when the requester is granted
//   cnt_q             current value of the shared counter
//   gnt[1:0]          one-hot owner (0 when idle)
//   done[1:0]         one-cycle completion pulse on the owner's bit
//   busy              high whenever an interval is in progress
//   cnt_clr, cnt_en   clear strobe and count enable to the shared counter
module counter_sched #(
    parameter int WIDTH = 4
) (
    input  logic             clock,
    input  logic             clear,
    input  logic [1:0]       req,
    input  logic [WIDTH-1:0] len0,
    input  logic [WIDTH-1:0] len1,
    input  logic [WIDTH-1:0] cnt_q,
    output logic [1:0]       gnt,
    output logic [1:0]       done,
    output logic             busy,
    output logic             cnt_clr,
    output logic             cnt_en
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;
    localparam logic [1:0] RUN  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ZERO = '0;

    logic [1:0]       state;
    logic             ptr;        // 0: requester 0 wins a tie, 1: requester 1 wins
    logic [WIDTH-1:0] len_lat;
    logic [1:0]       pick;
    logic [WIDTH-1:0] cnt_nxt;

    // A lone requester always wins; the pointer only breaks ties.
    always_comb begin
        pick = req;
        if (req == 2'b11) begin
            pick = ptr ? 2'b10 : 2'b01;
        end
    end

    // Value the counter will hold next cycle while it is enabled.
    assign cnt_nxt = cnt_q + ONE;

    assign busy = (state != IDLE);

    always_ff @(posedge clock) begin
        if (clear) begin
            state   <= IDLE;
            ptr     <= 1'b0;
            len_lat <= ZERO;
            gnt     <= 2'b00;
            done    <= 2'b00;
            cnt_clr <= 1'b0;
            cnt_en  <= 1'b0;
        end else begin
            cnt_clr <= 1'b0;
            done    <= 2'b00;
            case (state)
                IDLE: begin
                    if (|req) begin
                        gnt     <= pick;
                        len_lat <= pick[1] ? len1 : len0;
                        cnt_clr <= 1'b1;
                        state   <= LOAD;
                    end
                end
                LOAD: begin
                    // Counter reads 0 in the first RUN cycle, so a zero length
                    // never enables it.
                    cnt_en <= (len_lat != ZERO);
                    state  <= RUN;
                end
                RUN: begin
                    // cnt_en is registered: it is computed one cycle ahead from
                    // the value the counter is about to take, so it is already
                    // low in the cycle where cnt_q matches len_lat.
                    if (cnt_q == len_lat) begin
                        cnt_en <= 1'b0;
                        done   <= gnt;
                        state  <= DONE;
                    end else begin
                        cnt_en <= (cnt_nxt != len_lat);
                    end
                end
                DONE: begin
                    gnt   <= 2'b00;
                    ptr   <= ~ptr;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_counter_sched.sv
module tb_counter_sched;

    localparam int WIDTH = 4;

    logic             clock = 1'b0;
    logic             clear;
    logic [1:0]       req;
    logic [WIDTH-1:0] len0;
    logic [WIDTH-1:0] len1;
    logic [WIDTH-1:0] cnt_q;
    logic [1:0]       gnt;
    logic [1:0]       done;
    logic             busy;
    logic             cnt_clr;
    logic             cnt_en;

    int errors = 0;
    int checks = 0;

    // Observed and expected output vectors: {gnt, done, busy, cnt_clr, cnt_en}
    logic [6:0] obs;
    logic [6:0] exp_v;
    logic [1:0] eg;
    logic [1:0] ed;
    logic       ec;
    logic       ee;

    counter_sched #(.WIDTH(WIDTH)) dut (
        .clock  (clock),
        .clear  (clear),
        .req    (req),
        .len0   (len0),
        .len1   (len1),
        .cnt_q  (cnt_q),
        .gnt    (gnt),
        .done   (done),
        .busy   (busy),
        .cnt_clr(cnt_clr),
        .cnt_en (cnt_en)
    );

    always #5 clock = ~clock;

    // Shared counter: synchronous clear, count enable.
    always @(posedge clock) begin
        if (clear || cnt_clr) cnt_q <= '0;
        else if (cnt_en)      cnt_q <= cnt_q + 4'd1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "timeout");
    end

    task automatic test_reset();
        clear = 1'b1;
        req   = 2'b00;
        len0  = '0;
        len1  = '0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        obs = {gnt, done, busy, cnt_clr, cnt_en};
        checks++;
        if (obs !== 7'b0) begin
            errors++;
            $display("FAIL reset_hold: got %b want %b", obs, 7'b0);
        end
        clear = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            obs = {gnt, done, busy, cnt_clr, cnt_en};
            checks++;
            if (obs !== 7'b0) begin
                errors++;
                $display("FAIL reset_idle cyc %0d: got %b want %b", k, obs, 7'b0);
            end
        end
    endtask

    // req=01, len0=3
    task automatic test_single();
        for (int k = 0; k <= 8; k++) begin
            @(negedge clock);
            eg = (k >= 1 && k <= 6) ? 2'b01 : 2'b00;
            ed = (k == 6) ? 2'b01 : 2'b00;
            ec = (k == 1);
            ee = (k >= 2 && k <= 4);
            exp_v = {eg, ed, |eg, ec, ee};
            obs = {gnt, done, busy, cnt_clr, cnt_en};
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL single cyc %0d: got %b want %b", k, obs, exp_v);
            end
            if (k >= 2 && k <= 5) begin
                checks++;
                if (cnt_q !== 4'(k - 2)) begin
                    errors++;
                    $display("FAIL single_cnt cyc %0d: got %0d want %0d", k, cnt_q, k - 2);
                end
            end
            if (k == 0) begin
                req  = 2'b01;
                len0 = 4'd3;
            end
            if (k == 1) req = 2'b00;
        end
    endtask

    // req=10, len1=0
    task automatic test_zero_len();
        for (int k = 0; k <= 5; k++) begin
            @(negedge clock);
            eg = (k >= 1 && k <= 3) ? 2'b10 : 2'b00;
            ed = (k == 3) ? 2'b10 : 2'b00;
            ec = (k == 1);
            ee = 1'b0;
            exp_v = {eg, ed, |eg, ec, ee};
            obs = {gnt, done, busy, cnt_clr, cnt_en};
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL zero_len cyc %0d: got %b want %b", k, obs, exp_v);
            end
            if (k == 0) begin
                req  = 2'b10;
                len1 = 4'd0;
            end
            if (k == 1) req = 2'b00;
        end
    endtask

    // From reset: req=11 held, len0=2, len1=5; req dropped at cycle 17.
    task automatic test_back_to_back();
        clear = 1'b1;
        @(negedge clock);
        clear = 1'b0;
        for (int k = 0; k <= 22; k++) begin
            @(negedge clock);
            if ((k >= 1 && k <= 5) || (k >= 16 && k <= 20)) eg = 2'b01;
            else if (k >= 7 && k <= 14)                      eg = 2'b10;
            else                                             eg = 2'b00;
            ed = (k == 5 || k == 20) ? 2'b01 : ((k == 14) ? 2'b10 : 2'b00);
            ec = (k == 1 || k == 7 || k == 16);
            ee = (k >= 2 && k <= 3) || (k >= 8 && k <= 12) || (k >= 17 && k <= 18);
            exp_v = {eg, ed, |eg, ec, ee};
            obs = {gnt, done, busy, cnt_clr, cnt_en};
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL contention cyc %0d: got %b want %b", k, obs, exp_v);
            end
            if (k == 0) begin
                req  = 2'b11;
                len0 = 4'd2;
                len1 = 4'd5;
            end
            if (k == 17) req = 2'b00;
        end
    endtask

    // req=01, len0=3; at cycle 3 req drops and len0 becomes 9.
    task automatic test_ignored_changes();
        for (int k = 0; k <= 8; k++) begin
            @(negedge clock);
            eg = (k >= 1 && k <= 6) ? 2'b01 : 2'b00;
            ed = (k == 6) ? 2'b01 : 2'b00;
            ec = (k == 1);
            ee = (k >= 2 && k <= 4);
            exp_v = {eg, ed, |eg, ec, ee};
            obs = {gnt, done, busy, cnt_clr, cnt_en};
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL ignored cyc %0d: got %b want %b", k, obs, exp_v);
            end
            if (k == 5) begin
                checks++;
                if (cnt_q !== 4'd3) begin
                    errors++;
                    $display("FAIL ignored_cnt: got %0d want 3", cnt_q);
                end
            end
            if (k == 0) begin
                req  = 2'b01;
                len0 = 4'd3;
            end
            if (k == 3) begin
                req  = 2'b00;
                len0 = 4'd9;
            end
        end
    endtask

    // req=01, len0=15: counter reaches its maximum without wrapping.
    task automatic test_max_len();
        for (int k = 0; k <= 20; k++) begin
            @(negedge clock);
            eg = (k >= 1 && k <= 18) ? 2'b01 : 2'b00;
            ed = (k == 18) ? 2'b01 : 2'b00;
            ec = (k == 1);
            ee = (k >= 2 && k <= 16);
            exp_v = {eg, ed, |eg, ec, ee};
            obs = {gnt, done, busy, cnt_clr, cnt_en};
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL max_len cyc %0d: got %b want %b", k, obs, exp_v);
            end
            if (k == 17 || k == 18) begin
                checks++;
                if (cnt_q !== 4'd15) begin
                    errors++;
                    $display("FAIL max_len_cnt cyc %0d: got %0d want 15", k, cnt_q);
                end
            end
            if (k == 0) begin
                req  = 2'b01;
                len0 = 4'd15;
            end
            if (k == 1) req = 2'b00;
        end
    endtask

    // req=01, len0=5; clear on cycle 4; then req=11 with len0=1 from cycle 5.
    task automatic test_reset_mid_run();
        for (int k = 0; k <= 11; k++) begin
            @(negedge clock);
            eg = ((k >= 1 && k <= 4) || (k >= 6 && k <= 9)) ? 2'b01 : 2'b00;
            ed = (k == 9) ? 2'b01 : 2'b00;
            ec = (k == 1 || k == 6);
            ee = (k >= 2 && k <= 4) || (k == 7);
            exp_v = {eg, ed, |eg, ec, ee};
            obs = {gnt, done, busy, cnt_clr, cnt_en};
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL mid_reset cyc %0d: got %b want %b", k, obs, exp_v);
            end
            if (k == 0) begin
                req  = 2'b01;
                len0 = 4'd5;
            end
            if (k == 1) req = 2'b00;
            if (k == 4) clear = 1'b1;
            if (k == 5) begin
                clear = 1'b0;
                req   = 2'b11;
                len0  = 4'd1;
                len1  = 4'd7;
            end
            if (k == 6) req = 2'b00;
        end
    endtask

    initial begin
        clear = 1'b1;
        req   = 2'b00;
        len0  = '0;
        len1  = '0;
        test_reset();
        test_single();
        test_zero_len();
        test_back_to_back();
        test_ignored_changes();
        test_max_len();
        test_reset_mid_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
